// File: rtl/self_destruct_sequencer.sv
// rtl/self_destruct_sequencer.sv - self-destruct countdown sequencer and 8-LED display driver
// Optional feature macro: SELF_DESTRUCT_ABORT_EN (in_combat=0 aborts a running countdown)
module self_destruct_sequencer #(
    parameter int unsigned TICKS_PER_STEP = 100,
    parameter int unsigned ARM_TICKS      = 50,
    parameter int unsigned BLINK_TICKS    = 33
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       in_combat,
    input  logic       danger,
    input  logic       damaged,
    input  logic       immobilized,
    output logic [7:0] leds,
    output logic [2:0] state,
    output logic       detonated
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COMBAT    = 3'd1,
        S_ARMING    = 3'd2,
        S_COUNTDOWN = 3'd3,
        S_DETONATED = 3'd4
    } state_t;

`ifdef SELF_DESTRUCT_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    localparam logic [7:0] ARM_LAST   = 8'(ARM_TICKS - 1);
    localparam logic [7:0] STEP_LAST  = 8'(TICKS_PER_STEP - 1);
    localparam logic [7:0] BLINK_LAST = 8'(BLINK_TICKS - 1);

    state_t     state_q, state_d;
    logic [7:0] mask_q, mask_d;
    logic [7:0] arm_cnt_q, arm_cnt_d;
    logic [7:0] step_cnt_q, step_cnt_d;
    logic [7:0] blink_cnt_q, blink_cnt_d;
    logic       blink_phase_q, blink_phase_d;
    logic [7:0] leds_q, leds_d;
    logic       det_q, det_d;
    logic       vote;
    logic       blink_run;

    assign vote = (danger & damaged) | (danger & immobilized) | (damaged & immobilized);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            mask_q        <= 8'hFF;
            arm_cnt_q     <= 8'd0;
            step_cnt_q    <= 8'd0;
            blink_cnt_q   <= 8'd0;
            blink_phase_q <= 1'b1;
            leds_q        <= 8'd0;
            det_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            mask_q        <= mask_d;
            arm_cnt_q     <= arm_cnt_d;
            step_cnt_q    <= step_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            leds_q        <= leds_d;
            det_q         <= det_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        mask_d        = mask_q;
        arm_cnt_d     = arm_cnt_q;
        step_cnt_d    = step_cnt_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        blink_run     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_combat) state_d = S_COMBAT;
            end
            S_COMBAT: begin
                if (!in_combat) begin
                    state_d = S_IDLE;
                end else if (vote) begin
                    state_d       = S_ARMING;
                    arm_cnt_d     = 8'd0;
                    blink_cnt_d   = 8'd0;
                    blink_phase_d = 1'b1;
                end
            end
            S_ARMING: begin
                if (!in_combat) begin
                    state_d = S_IDLE;
                end else if (!vote) begin
                    state_d   = S_COMBAT;
                    arm_cnt_d = 8'd0;
                end else if (tick) begin
                    blink_run = 1'b1;
                    if (arm_cnt_q == ARM_LAST) begin
                        state_d    = S_COUNTDOWN;
                        mask_d     = 8'hFF;
                        step_cnt_d = 8'd0;
                    end else begin
                        arm_cnt_d = arm_cnt_q + 8'd1;
                    end
                end
            end
            S_COUNTDOWN: begin
                if (tick) begin
                    blink_run = 1'b1;
                    if (step_cnt_q == STEP_LAST) begin
                        step_cnt_d = 8'd0;
                        mask_d     = mask_q >> 1;
                        if (mask_q[7:1] == 7'd0) state_d = S_DETONATED;
                    end else begin
                        step_cnt_d = step_cnt_q + 8'd1;
                    end
                end
                // A coincident final step beats the abort.
                if (ABORT_EN && !in_combat && state_d != S_DETONATED) begin
                    state_d       = S_IDLE;
                    mask_d        = 8'hFF;
                    step_cnt_d    = 8'd0;
                    blink_cnt_d   = 8'd0;
                    blink_phase_d = 1'b1;
                    blink_run     = 1'b0;
                end
            end
            S_DETONATED: begin
                state_d = S_DETONATED;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (blink_run) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d   = 8'd0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 8'd1;
            end
        end
    end

    // Outputs are decoded from next-state values so they register on the same edge.
    always_comb begin
        leds_d = 8'd0;
        det_d  = 1'b0;
        case (state_d)
            S_COMBAT:    leds_d = {5'b0, immobilized, damaged, danger};
            S_ARMING:    leds_d = blink_phase_d ? 8'hFF : 8'h00;
            S_COUNTDOWN: leds_d = blink_phase_d ? mask_d : 8'h00;
            S_DETONATED: begin
                leds_d = 8'hFF;
                det_d  = 1'b1;
            end
            default:     leds_d = 8'd0;
        endcase
    end

    assign leds      = leds_q;
    assign state     = state_q;
    assign detonated = det_q;

endmodule

// File: tb/tb_self_destruct_sequencer.sv
// tb/tb_self_destruct_sequencer.sv - randomized and directed bench for self_destruct_sequencer
module tb_self_destruct_sequencer;

    localparam int STEP  = 4;
    localparam int ARM   = 3;
    localparam int BLINK = 2;
`ifdef SELF_DESTRUCT_ABORT_EN
    localparam bit ABORT = 1'b1;
`else
    localparam bit ABORT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic       in_combat = 1'b0;
    logic       danger = 1'b0;
    logic       damaged = 1'b0;
    logic       immobilized = 1'b0;
    logic [7:0] leds;
    logic [2:0] state;
    logic       detonated;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: elapsed-tick counts since phase entry, outputs derived arithmetically.
    int         m_state = 0;
    int         arm_t = 0;
    int         cd_t = 0;
    int         blink_t = 0;
    logic [7:0] m_leds = 8'd0;

    self_destruct_sequencer #(
        .TICKS_PER_STEP(STEP),
        .ARM_TICKS     (ARM),
        .BLINK_TICKS   (BLINK)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .in_combat  (in_combat),
        .danger     (danger),
        .damaged    (damaged),
        .immobilized(immobilized),
        .leds       (leds),
        .state      (state),
        .detonated  (detonated)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input logic t, input logic ic, input logic dn, input logic dm, input logic im);
        bit vote;
        bit fin;
        bit ph;
        vote = (int'(dn) + int'(dm) + int'(im)) >= 2;
        case (m_state)
            0: if (ic) m_state = 1;
            1: begin
                if (!ic) m_state = 0;
                else if (vote) begin
                    m_state = 2;
                    arm_t   = 0;
                    blink_t = 0;
                end
            end
            2: begin
                if (!ic) m_state = 0;
                else if (!vote) m_state = 1;
                else if (t) begin
                    arm_t++;
                    blink_t++;
                    if (arm_t == ARM) begin
                        m_state = 3;
                        cd_t    = 0;
                    end
                end
            end
            3: begin
                fin = t && (cd_t + 1 == 8 * STEP);
                if (ABORT && !ic && !fin) m_state = 0;
                else if (t) begin
                    cd_t++;
                    blink_t++;
                    if (cd_t == 8 * STEP) m_state = 4;
                end
            end
            default: m_state = 4;
        endcase
        ph = ((blink_t / BLINK) % 2) == 0;
        case (m_state)
            0: m_leds = 8'h00;
            1: m_leds = {5'b0, im, dm, dn};
            2: m_leds = ph ? 8'hFF : 8'h00;
            3: m_leds = ph ? (8'hFF >> (cd_t / STEP)) : 8'h00;
            default: m_leds = 8'hFF;
        endcase
    endtask

    task automatic cyc(input logic t, input logic ic, input logic dn, input logic dm, input logic im);
        tick        = t;
        in_combat   = ic;
        danger      = dn;
        damaged     = dm;
        immobilized = im;
        @(posedge clk);
        model_edge(t, ic, dn, dm, im);
        @(negedge clk);
        check_eq("state", 32'(state), 32'(m_state));
        check_eq("leds", 32'(leds), 32'(m_leds));
        check_eq("detonated", 32'(detonated), 32'(m_state == 4));
    endtask

    task automatic ticks(input int n, input logic ic, input logic dn, input logic dm, input logic im);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) cyc(1'b0, ic, dn, dm, im);
            cyc(1'b1, ic, dn, dm, im);
        end
    endtask

    task automatic async_reset();
        #2 reset = 1'b0;
        #1;
        check_eq("rst_state", 32'(state), 32'd0);
        check_eq("rst_leds", 32'(leds), 32'd0);
        check_eq("rst_det", 32'(detonated), 32'd0);
        m_state = 0;
        arm_t   = 0;
        cd_t    = 0;
        blink_t = 0;
        m_leds  = 8'd0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic ic, dn, dm, im;
        @(negedge clk);
        check_eq("init_state", 32'(state), 32'd0);
        check_eq("init_leds", 32'(leds), 32'd0);
        check_eq("init_det", 32'(detonated), 32'd0);
        reset = 1'b1;

        // Full detonation, then sticky hold
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        check_eq("enter_arming", 32'(state), 32'd2);
        ticks(ARM, 1'b1, 1'b1, 1'b1, 1'b0);
        check_eq("enter_countdown", 32'(state), 32'd3);
        ticks(8 * STEP, 1'b1, 1'b1, 1'b1, 1'b0);
        check_eq("boom_state", 32'(state), 32'd4);
        check_eq("boom_leds", 32'(leds), 32'hFF);
        check_eq("boom_det", 32'(detonated), 32'd1);
        ticks(100, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("sticky_state", 32'(state), 32'd4);
        check_eq("sticky_leds", 32'(leds), 32'hFF);
        async_reset();

        // Single danger input never arms
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        ticks(20, 1'b1, 1'b0, 1'b0, 1'b1);
        check_eq("single_state", 32'(state), 32'd1);
        check_eq("single_leds", 32'(leds), 32'h04);

        // Vote dropout restarts the arming count
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        ticks(ARM - 1, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("dropout_state", 32'(state), 32'd1);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        ticks(ARM - 1, 1'b1, 1'b0, 1'b1, 1'b1);
        check_eq("rearm_partial", 32'(state), 32'd2);
        ticks(1, 1'b1, 1'b0, 1'b1, 1'b1);
        check_eq("rearm_done", 32'(state), 32'd3);

        // Blink through mask 7F, then abort at mask 3F
        ticks(2 * STEP, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check_eq("abort_state", 32'(state), ABORT ? 32'd0 : 32'd3);
        ticks(6 * STEP, 1'b0, 1'b0, 1'b1, 1'b1);
        check_eq("abort_end", 32'(state), ABORT ? 32'd0 : 32'd4);
        async_reset();

        // Abort coinciding with the final step tick detonates
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        ticks(ARM + 8 * STEP - 1, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        check_eq("final_tick_state", 32'(state), 32'd4);
        check_eq("final_tick_det", 32'(detonated), 32'd1);
        async_reset();

        // Random walk with slowly changing levels and occasional resets
        ic = 1'b1;
        dn = 1'b0;
        dm = 1'b0;
        im = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 59) == 0) ic = ~ic;
            if ($urandom_range(0, 14) == 0) dn = ~dn;
            if ($urandom_range(0, 14) == 0) dm = ~dm;
            if ($urandom_range(0, 14) == 0) im = ~im;
            if ($urandom_range(0, 299) == 0) async_reset();
            else cyc(1'($urandom_range(0, 1)), ic, dn, dm, im);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
